// File: rtl/filter_cmd_rx.sv
// filter_cmd_rx: 8N1 UART receiver that turns framed bytes into filter
// command codes for the pixel filter stage.
// Optional build macro: CMD_RANGE_CHECK_EN -- when defined, only ASCII
// '0'..'8' (8'h30..8'h38) are accepted as commands; other framed bytes
// still pulse byte_valid but leave oper untouched.
module filter_cmd_rx #(
  parameter int unsigned CLK_HZ = 100000000,
  parameter int unsigned BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] oper,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       cmd_update,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned DIV  = CLK_HZ / BAUD;
  localparam int unsigned HALF = DIV / 2;
  localparam int unsigned TW   = (DIV > 2) ? $clog2(DIV) : 1;

  localparam logic [TW-1:0] HALF_M1 = TW'(HALF - 1);
  localparam logic [TW-1:0] DIV_M1  = TW'(DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t        state;
  logic [1:0]    sync;
  logic          rxd_s;
  logic          rxd_prev;
  logic [TW-1:0] timer;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          cmd_ok;

  assign rxd_s = sync[1];

`ifdef CMD_RANGE_CHECK_EN
  assign cmd_ok = (shreg >= 8'h30) && (shreg <= 8'h38);
`else
  assign cmd_ok = 1'b1;
`endif

  // Two-flop synchronizer plus one delayed copy for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync     <= '1;
      rxd_prev <= 1'b1;
    end else begin
      sync     <= {sync[0], rxd};
      rxd_prev <= rxd_s;
    end
  end

  // Receive FSM with registered pulses, byte capture and command register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      timer      <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      oper       <= 8'h30;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      cmd_update <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      cmd_update <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (rxd_prev && !rxd_s) begin
            state <= START;
            timer <= '0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (timer == HALF_M1) begin
            timer <= '0;
            if (!rxd_s) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DATA: begin
          if (timer == DIV_M1) begin
            timer <= '0;
            shreg <= {rxd_s, shreg[7:1]};
            // Counter parks at 7 instead of wrapping; STOP needs no index.
            if (bit_cnt == 3'd7) begin
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        STOP: begin
          if (timer == DIV_M1) begin
            timer <= '0;
            if (rxd_s) begin
              byte_valid <= 1'b1;
              rx_byte    <= shreg;
              if (cmd_ok) begin
                oper       <= shreg;
                cmd_update <= (shreg != oper);
              end
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        BREAK: begin
          if (rxd_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_filter_cmd_rx.sv
// Directed bench for filter_cmd_rx at CLK_HZ=1 MHz, BAUD=100 kbaud (DIV=10).
module tb_filter_cmd_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic [7:0] oper;
  logic [7:0] rx_byte;
  logic       byte_valid;
  logic       cmd_update;
  logic       frame_err;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_bv = 0;
  int n_cu = 0;
  int n_fe = 0;
  int bv_cyc = 0;

  filter_cmd_rx #(.CLK_HZ(1000000), .BAUD(100000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rxd        (rxd),
    .oper       (oper),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .cmd_update (cmd_update),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse counters sampled on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (byte_valid === 1'b1) begin
      n_bv++;
      bv_cyc = cyc;
    end
    if (cmd_update === 1'b1) n_cu++;
    if (frame_err === 1'b1) n_fe++;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic lvl);
    rxd = lvl;
    idle(10);
  endtask

  task automatic send_byte(input logic [7:0] b);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rxd   = 1'b1;
    idle(3);
    checks++; if (oper !== 8'h30) begin errors++; $display("FAIL reset_oper got %h want %h", oper, 8'h30); end
    checks++; if (rx_byte !== 8'h00) begin errors++; $display("FAIL reset_rx_byte got %h want %h", rx_byte, 8'h00); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (byte_valid !== 1'b0) begin errors++; $display("FAIL reset_byte_valid got %b want 0", byte_valid); end
    checks++; if (cmd_update !== 1'b0) begin errors++; $display("FAIL reset_cmd_update got %b want 0", cmd_update); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
    rst_n = 1'b1;
    idle(5);
  endtask

  task automatic test_basic();
    int bv0, cu0, t0;
    bv0 = n_bv; cu0 = n_cu;
    t0 = cyc;
    send_byte(8'h33);
    idle(5);
    checks++; if (n_bv - bv0 !== 1) begin errors++; $display("FAIL basic_bv_count got %0d want 1", n_bv - bv0); end
    checks++; if (n_cu - cu0 !== 1) begin errors++; $display("FAIL basic_cu_count got %0d want 1", n_cu - cu0); end
    checks++; if (rx_byte !== 8'h33) begin errors++; $display("FAIL basic_rx_byte got %h want %h", rx_byte, 8'h33); end
    checks++; if (oper !== 8'h33) begin errors++; $display("FAIL basic_oper got %h want %h", oper, 8'h33); end
    checks++; if (bv_cyc - t0 !== 98) begin errors++; $display("FAIL basic_latency got %0d want 98", bv_cyc - t0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy got %b want 0", busy); end
  endtask

  task automatic test_glitch();
    int bv0, cu0, fe0;
    bv0 = n_bv; cu0 = n_cu; fe0 = n_fe;
    rxd = 1'b0;
    idle(3);
    rxd = 1'b1;
    idle(2);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_start got %b want 1", busy); end
    idle(10);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_end got %b want 0", busy); end
    checks++; if (n_bv - bv0 !== 0) begin errors++; $display("FAIL glitch_bv_count got %0d want 0", n_bv - bv0); end
    checks++; if ((n_cu - cu0) + (n_fe - fe0) !== 0) begin errors++; $display("FAIL glitch_pulses got %0d want 0", (n_cu - cu0) + (n_fe - fe0)); end
    checks++; if (oper !== 8'h33) begin errors++; $display("FAIL glitch_oper got %h want %h", oper, 8'h33); end
  endtask

  task automatic test_range();
    int bv0, cu0;
    logic [7:0] exp_oper;
    int exp_cu;
`ifdef CMD_RANGE_CHECK_EN
    exp_oper = 8'h33; exp_cu = 0;
`else
    exp_oper = 8'h41; exp_cu = 1;
`endif
    bv0 = n_bv; cu0 = n_cu;
    send_byte(8'h41);
    idle(5);
    checks++; if (n_bv - bv0 !== 1) begin errors++; $display("FAIL range_bv_count got %0d want 1", n_bv - bv0); end
    checks++; if (rx_byte !== 8'h41) begin errors++; $display("FAIL range_rx_byte got %h want %h", rx_byte, 8'h41); end
    checks++; if (oper !== exp_oper) begin errors++; $display("FAIL range_oper got %h want %h", oper, exp_oper); end
    checks++; if (n_cu - cu0 !== exp_cu) begin errors++; $display("FAIL range_cu_count got %0d want %0d", n_cu - cu0, exp_cu); end
  endtask

  task automatic test_frame_err();
    int bv0, cu0, fe0;
    logic [7:0] b;
    b = 8'h35;
    bv0 = n_bv; fe0 = n_fe;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    rxd = 1'b0;
    idle(30);
    checks++; if (n_fe - fe0 !== 1) begin errors++; $display("FAIL ferr_fe_count got %0d want 1", n_fe - fe0); end
    checks++; if (n_bv - bv0 !== 0) begin errors++; $display("FAIL ferr_bv_count got %0d want 0", n_bv - bv0); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ferr_busy_break got %b want 1", busy); end
    checks++; if (rx_byte !== 8'h41) begin errors++; $display("FAIL ferr_rx_byte got %h want %h", rx_byte, 8'h41); end
    rxd = 1'b1;
    idle(10);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_busy_idle got %b want 0", busy); end
    bv0 = n_bv; cu0 = n_cu;
    send_byte(8'h36);
    idle(5);
    checks++; if (n_bv - bv0 !== 1) begin errors++; $display("FAIL ferr_next_bv got %0d want 1", n_bv - bv0); end
    checks++; if (rx_byte !== 8'h36) begin errors++; $display("FAIL ferr_next_rx_byte got %h want %h", rx_byte, 8'h36); end
    checks++; if (oper !== 8'h36) begin errors++; $display("FAIL ferr_next_oper got %h want %h", oper, 8'h36); end
    checks++; if (n_cu - cu0 !== 1) begin errors++; $display("FAIL ferr_next_cu got %0d want 1", n_cu - cu0); end
  endtask

  task automatic test_back_to_back();
    int bv0, cu0;
    bv0 = n_bv;
    cu0 = n_cu;
    send_byte(8'h31);
    checks++; if (n_cu - cu0 !== 1) begin errors++; $display("FAIL b2b_cu_first got %0d want 1", n_cu - cu0); end
    cu0 = n_cu;
    send_byte(8'h31);
    checks++; if (n_cu - cu0 !== 0) begin errors++; $display("FAIL b2b_cu_second got %0d want 0", n_cu - cu0); end
    cu0 = n_cu;
    send_byte(8'h38);
    idle(5);
    checks++; if (n_cu - cu0 !== 1) begin errors++; $display("FAIL b2b_cu_third got %0d want 1", n_cu - cu0); end
    checks++; if (n_bv - bv0 !== 3) begin errors++; $display("FAIL b2b_bv_count got %0d want 3", n_bv - bv0); end
    checks++; if (oper !== 8'h38) begin errors++; $display("FAIL b2b_oper got %h want %h", oper, 8'h38); end
    checks++; if (rx_byte !== 8'h38) begin errors++; $display("FAIL b2b_rx_byte got %h want %h", rx_byte, 8'h38); end
  endtask

  task automatic test_reset_midframe();
    int bv0, cu0, fe0;
    logic [7:0] b;
    b = 8'h32;
    bv0 = n_bv; fe0 = n_fe;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    rxd = b[4];
    idle(5);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (oper !== 8'h30) begin errors++; $display("FAIL mid_oper got %h want %h", oper, 8'h30); end
    checks++; if (rx_byte !== 8'h00) begin errors++; $display("FAIL mid_rx_byte got %h want %h", rx_byte, 8'h00); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", busy); end
    idle(3);
    rxd = 1'b1;
    rst_n = 1'b1;
    idle(120);
    checks++; if (n_bv - bv0 !== 0) begin errors++; $display("FAIL mid_bv_count got %0d want 0", n_bv - bv0); end
    checks++; if (n_fe - fe0 !== 0) begin errors++; $display("FAIL mid_fe_count got %0d want 0", n_fe - fe0); end
    bv0 = n_bv; cu0 = n_cu;
    send_byte(8'h34);
    idle(5);
    checks++; if (n_bv - bv0 !== 1) begin errors++; $display("FAIL mid_next_bv got %0d want 1", n_bv - bv0); end
    checks++; if (oper !== 8'h34) begin errors++; $display("FAIL mid_next_oper got %h want %h", oper, 8'h34); end
    checks++; if (rx_byte !== 8'h34) begin errors++; $display("FAIL mid_next_rx_byte got %h want %h", rx_byte, 8'h34); end
    checks++; if (n_cu - cu0 !== 1) begin errors++; $display("FAIL mid_next_cu got %0d want 1", n_cu - cu0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_range();
    test_frame_err();
    test_back_to_back();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/filter_cmd_rx.md
FILTER_CMD_RX -- requirements
Module: filter_cmd_rx

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 100000000, meaning system clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 115200, meaning serial bit rate; DIV = CLK_HZ/BAUD (integer, truncated) and HALF = DIV/2.
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 rxd  input  1  UART serial line, 8N1, LSB first, idle high; asynchronous to clk.
REQ-006 oper  output  8  current filter command code, held until the next accepted command; feeds the pixel filter stage.
REQ-007 rx_byte  output  8  last correctly framed byte, whether or not it was accepted as a command.
REQ-008 byte_valid  output  1  one-cycle pulse on every correctly framed byte.
REQ-009 cmd_update  output  1  one-cycle pulse when oper takes a new value.
REQ-010 frame_err  output  1  one-cycle pulse when the stop bit samples low.
REQ-011 busy  output  1  high in every state except IDLE.

Function
REQ-012 rxd SHALL pass through a 2-flop synchronizer, initialized high, before any use; all timing below refers to the synchronized signal.
REQ-013 The FSM SHALL have states IDLE, START, DATA, STOP and BREAK.
REQ-014 IDLE: a high-to-low transition of synchronized rxd SHALL move to START and clear the bit-timer.
REQ-015 START: at timer = HALF-1, if rxd is low go to DATA with the timer cleared; if high, treat the edge as a glitch and return to IDLE with no output pulse.
REQ-016 DATA: every DIV clocks, sample rxd into bit index 0..7 (LSB first); after bit 7 go to STOP.
REQ-017 STOP: DIV clocks after bit 7, sample rxd; if high, pulse byte_valid, load rx_byte and return to IDLE; if low, pulse frame_err, leave rx_byte unchanged and go to BREAK.
REQ-018 BREAK SHALL wait until rxd is high, then return to IDLE; falling edges are not detected in BREAK.
REQ-019 Pulses SHALL assert in the clock cycle immediately after the stop-bit sample edge.
REQ-020 On a command accept, oper SHALL update in the same cycle as byte_valid, and cmd_update SHALL pulse only if the new value differs from the old one.
REQ-021 The bit-timer SHALL be wide enough to hold DIV-1 without overflow; the bit counter SHALL be 3 bits and SHALL not wrap mid-frame.
REQ-022 A falling edge that occurs in the cycle the FSM returns to IDLE SHALL be detected on the next cycle; back-to-back frames with a single stop bit SHALL be received without loss.

Reset
REQ-023 Asserting rst_n low SHALL force, immediately and at any point including mid-frame: state IDLE, oper = 8'h30, rx_byte = 8'h00, byte_valid, cmd_update and frame_err = 0, busy = 0, synchronizer = 1.
REQ-024 A partial frame interrupted by reset SHALL be discarded; after release, reception SHALL resume at the next falling edge.

Configuration
REQ-025 Macro CMD_RANGE_CHECK_EN: when defined, oper SHALL load only bytes 8'h30..8'h38 (ASCII '0'..'8'), and other framed bytes SHALL pulse byte_valid without changing oper; when undefined, every framed byte SHALL load oper.

Verification (CLK_HZ=1000000, BAUD=100000, DIV=10)
REQ-026 Send 8'h33 after reset -> byte_valid pulse, rx_byte=8'h33, oper=8'h33, cmd_update pulse; pulse one cycle after the stop-bit sample (about 95 clocks after the start edge plus 2 sync cycles).
REQ-027 Low glitch of 3 clocks on an idle line -> START aborts, no pulses, busy returns low, oper unchanged.
REQ-028 Send 8'h41 with CMD_RANGE_CHECK_EN defined -> byte_valid, rx_byte=8'h41, oper stays at its prior value, no cmd_update; with the macro undefined -> oper=8'h41 and cmd_update pulses.
REQ-029 Frame 8'h35 with the stop bit held low for 30 clocks -> frame_err pulse, no byte_valid, FSM in BREAK until rxd is high; then 8'h36 is received correctly.
REQ-030 Back-to-back 8'h31, 8'h31, 8'h38 with no idle gap -> three byte_valid pulses, cmd_update only on the first and third byte, final oper=8'h38.
REQ-031 rst_n pulsed low during data bit 4 of 8'h32 -> all outputs at reset values immediately, no pulse for the aborted frame; the next 8'h34 is received with oper=8'h34.
